booth_seq_mul: RTL
==================

Name: booth_seq_mul

Overview:
- Sequential radix-2 Booth signed multiplier controller.
- Reuses one shared WIDTH+1-bit add/subtract datapath, with a subtract-select input and two's-complement carry-in, once per cycle across WIDTH iterations.
- Sits between the operand source and the product consumer. Start/done handshake; one multiplication in flight.

Parameters:
- WIDTH, 4, operand width in bits (signed two's complement); product is 2*WIDTH bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplicand (signed), captured on accepted start.
- b  input  WIDTH  multiplier (signed), captured on accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; p valid.
- p  output  2*WIDTH  signed product; holds until next accepted start completes.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high: asserting rst clears all state immediately, independent of clk.
- Reset values: state=IDLE, busy=0, done=0, p=0, internal A/Q/q_m1/M/count=0.
- Registers:
  - A: WIDTH+1 bits, accumulator.
  - Q: WIDTH bits.
  - q_m1: 1 bit.
  - M: WIDTH+1 bits, a sign-extended.
  - count: clog2(WIDTH+1) bits.
- IDLE:
  - start=1 at edge k: A=0, Q=b, q_m1=0, M=sext(a), count=WIDTH, go to RUN.
  - start=0: stay in IDLE.
- RUN, one iteration per edge:
  - Booth pair {Q[0],q_m1}: 10 -> A=A-M (subtract-select=1); 01 -> A=A+M (subtract-select=0); 00/11 -> A unchanged. Add/sub overflow is discarded (wraps mod 2^(WIDTH+1)).
  - Then arithmetic right shift of {A',Q,q_m1} by 1: A MSB replicated.
  - count decrements. On the edge where count goes 1 -> 0, go to DONE and register p = {A_new[WIDTH-1:0], Q_new}.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH. Next start is accepted at edge k+WIDTH+2 at the earliest.
- start while busy=1 (RUN or DONE) is ignored; no queuing. a/b changes after acceptance have no effect.
- Range: the full signed range is supported, including -2^(WIDTH-1) * -2^(WIDTH-1) = +2^(2*WIDTH-2). The WIDTH+1-bit A prevents intermediate overflow.
- Reset mid-operation: abort immediately, outputs return to reset values. No done pulse for the aborted operation.
- p changes only on entry to DONE (or on reset).

Optional Feature:
- Macro: BOOTH_ZERO_SKIP_EN.
- Defined:
  - Accepted start with a==0 or b==0 skips RUN. Next state is DONE with p=0, so done is high in the cycle after edge k (latency 1).
  - busy is high for that single DONE cycle.
  - Nonzero operands behave exactly as without the macro.
- Undefined: all operations take the full WIDTH+1-cycle path, including zero operands.

Test Plan (WIDTH=4):
- Reset, then start with a=3, b=5 at edge k -> busy high from k+1; done single pulse after edge k+4; p=8'h0F; p holds 8'h0F afterwards.
- a=-8 (4'h8), b=-8 -> p=8'h40. a=-8, b=7 -> p=8'hC8. a=7, b=-1 -> p=8'hF9. Exhaustive sweep of all 256 pairs matches the signed reference product.
- start held high continuously with a=2, b=3 -> exactly one done per WIDTH+2 cycles. Operand changes during RUN do not affect the result, p=8'h06.
- Assert rst asynchronously (between edges) two cycles after start -> busy, done and p drop to 0 immediately. No done pulse follows. A fresh start then produces a correct result.
- With BOOTH_ZERO_SKIP_EN: a=0, b=-3 -> done high in the cycle after the start edge, p=8'h00. a=1, b=-3 -> normal latency, p=8'hFD. Without the macro: a=0, b=-3 -> done after edge k+4, p=8'h00.

Source files
------------

// File: rtl/booth_seq_mul.sv
// -----------------------------------------------------------------------------
// booth_seq_mul
//   Sequential radix-2 Booth signed multiplier. One shared WIDTH+1-bit
//   add/subtract datapath is reused once per cycle over WIDTH iterations.
//   Start/done handshake with a single multiplication in flight.
//
// Parameters
//   WIDTH    operand width (signed two's complement); product is 2*WIDTH bits
//
// Ports
//   clk_i    clock, rising edge
//   rst_i    asynchronous, active-high reset
//   start_i  request; sampled only while idle
//   a_i      multiplicand (signed), captured on accepted start
//   b_i      multiplier (signed), captured on accepted start
//   busy_o   high while running and during the done cycle
//   done_o   one-cycle pulse, p_o valid
//   p_o      signed product; holds until the next operation completes
//
// Optional feature macro: BOOTH_ZERO_SKIP_EN
//   When defined, an accepted start with a zero operand skips the iteration
//   phase and goes straight to the done cycle with a zero product.
// -----------------------------------------------------------------------------
module booth_seq_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   p_o
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef BOOTH_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Shared adder: sub selects ~y with carry-in 1 (two's-complement subtract).
    // Overflow wraps modulo 2^(WIDTH+1).
    function automatic logic [WIDTH:0] addsub(
        input logic [WIDTH:0] x,
        input logic [WIDTH:0] y,
        input logic           sub
    );
        logic [WIDTH:0] y_sel;
        y_sel = sub ? ~y : y;
        return x + y_sel + {{WIDTH{1'b0}}, sub};
    endfunction

    state_t               state_q, state_d;
    logic [WIDTH:0]       acc_q, acc_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 sub_s;
    logic                 add_en_s;
    logic [WIDTH:0]       sum_s;
    logic [WIDTH:0]       acc_new_s;
    logic [WIDTH:0]       acc_sh_s;
    logic [WIDTH-1:0]     q_sh_s;
    logic                 qm1_sh_s;
    logic                 zero_op_s;

    // Booth iteration datapath: optional add/sub then arithmetic right shift.
    always_comb begin
        sub_s     = q_q[0] & ~qm1_q;      // pair 10 -> subtract
        add_en_s  = q_q[0] ^ qm1_q;       // pairs 10/01 modify A
        sum_s     = addsub(acc_q, m_q, sub_s);
        if (add_en_s) begin
            acc_new_s = sum_s;
        end else begin
            acc_new_s = acc_q;
        end
        // Shift {A,Q,q_m1} right by one, replicating A's MSB.
        {acc_sh_s, q_sh_s, qm1_sh_s} = {acc_new_s[WIDTH], acc_new_s, q_q};
        zero_op_s = (a_i == {WIDTH{1'b0}}) || (b_i == {WIDTH{1'b0}});
    end

    // Next-state and next-output logic of the controller.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        count_d = count_q;
        p_d     = p_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (ZERO_SKIP && zero_op_s) begin
                        state_d = S_DONE;
                        p_d     = {(2*WIDTH){1'b0}};
                    end else begin
                        state_d = S_RUN;
                        acc_d   = {(WIDTH+1){1'b0}};
                        q_d     = b_i;
                        qm1_d   = 1'b0;
                        m_d     = {a_i[WIDTH-1], a_i};
                        count_d = CW'(WIDTH);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d   = acc_sh_s;
                q_d     = q_sh_s;
                qm1_d   = qm1_sh_s;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = S_DONE;
                    p_d     = {acc_sh_s[WIDTH-1:0], q_sh_s};
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            acc_q   <= {(WIDTH+1){1'b0}};
            q_q     <= {WIDTH{1'b0}};
            qm1_q   <= 1'b0;
            m_q     <= {(WIDTH+1){1'b0}};
            count_q <= {CW{1'b0}};
            p_q     <= {(2*WIDTH){1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            count_q <= count_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign p_o    = p_q;

endmodule
